// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed, wrap-aligned reconfiguration.
// Optional per-channel rising-edge tick output when CLKDIV_TICK_EN is defined.
module prog_clock_divider #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 24,
    parameter int DEFAULT_PERIOD = 12000000,
    parameter int DEFAULT_HIGH   = 6000000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    clk_out
`ifdef CLKDIV_TICK_EN
    ,
    output logic [NUM_CH-1:0]    tick
`endif
);

    logic [CNT_WIDTH-1:0] cnt       [NUM_CH];
    logic [CNT_WIDTH-1:0] period    [NUM_CH];
    logic [CNT_WIDTH-1:0] high      [NUM_CH];
    logic [CNT_WIDTH-1:0] sh_period [NUM_CH];
    logic [CNT_WIDTH-1:0] sh_high   [NUM_CH];
    logic [NUM_CH-1:0]    pend;

    logic                 ch_ok;
    logic                 cfg_legal;
    logic                 accept;
    logic [NUM_CH-1:0]    wrap;
    logic [NUM_CH-1:0]    load;
    logic [NUM_CH-1:0]    apply;

    // Out-of-range channels have no pending bit; they are always ready so the
    // handshake completes and the request can be flagged as an error.
    always_comb begin
        ch_ok     = (32'(cfg_ch) < 32'(NUM_CH));
        cfg_ready = ch_ok ? !pend[cfg_ch] : 1'b1;
        cfg_legal = ch_ok
                    && (cfg_period >= CNT_WIDTH'(2))
                    && (cfg_high >= CNT_WIDTH'(1))
                    && (cfg_high < cfg_period);
        accept    = cfg_valid && cfg_ready;
    end

    always_comb begin
        wrap  = '0;
        load  = '0;
        apply = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wrap[i]  = en[i] && (cnt[i] == period[i] - CNT_WIDTH'(1));
            load[i]  = accept && cfg_legal && (cfg_ch == CH_W'(i));
            apply[i] = pend[i] && (sync || !en[i] || wrap[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]       <= '0;
                period[i]    <= CNT_WIDTH'(DEFAULT_PERIOD);
                high[i]      <= CNT_WIDTH'(DEFAULT_HIGH);
                sh_period[i] <= '0;
                sh_high[i]   <= '0;
            end
            pend    <= '0;
            clk_out <= '0;
            cfg_err <= 1'b0;
`ifdef CLKDIV_TICK_EN
            tick    <= '0;
`endif
        end else begin
            cfg_err <= accept && !cfg_legal;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // load and apply are exclusive: load needs pend clear, apply needs it set.
                if (load[i]) begin
                    sh_period[i] <= cfg_period;
                    sh_high[i]   <= cfg_high;
                    pend[i]      <= 1'b1;
                end else if (apply[i]) begin
                    period[i]    <= sh_period[i];
                    high[i]      <= sh_high[i];
                    pend[i]      <= 1'b0;
                end

                if (!en[i] || sync || wrap[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);

                clk_out[i] <= en[i] && (cnt[i] < high[i]);
`ifdef CLKDIV_TICK_EN
                tick[i]    <= en[i] && (cnt[i] < high[i]) && !clk_out[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (NUM_CH=2, 8-bit, 10/5 defaults),
// plus a 3-channel instance used only for the out-of-range channel request.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_err;
    logic [1:0] clk_out;

    logic [2:0] en2;
    logic       cfg_valid2;
    logic       cfg_ready2;
    logic [1:0] cfg_ch2;
    logic [7:0] cfg_period2;
    logic [7:0] cfg_high2;
    logic       cfg_err2;
    logic [2:0] clk_out2;
`ifdef CLKDIV_TICK_EN
    logic [1:0] tick;
    logic [2:0] tick2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_clock_divider #(
        .NUM_CH(2), .CNT_WIDTH(8), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(5)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_err(cfg_err),
        .clk_out(clk_out)
`ifdef CLKDIV_TICK_EN
        , .tick(tick)
`endif
    );

    prog_clock_divider #(
        .NUM_CH(3), .CNT_WIDTH(8), .DEFAULT_PERIOD(10), .DEFAULT_HIGH(5)
    ) dut3 (
        .clk(clk), .rst(rst), .en(en2), .sync(1'b0),
        .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .cfg_ch(cfg_ch2),
        .cfg_period(cfg_period2), .cfg_high(cfg_high2), .cfg_err(cfg_err2),
        .clk_out(clk_out2)
`ifdef CLKDIV_TICK_EN
        , .tick(tick2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic e0, e1;
        rst = 1'b1; en = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        en2 = '0; cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_period2 = '0; cfg_high2 = '0;
        repeat (3) step();
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        step();

        // Cycle 0: enable both channels; first rise visible in cycle 1.
        en = 2'b11;
        check("en_c0", 32'(clk_out), 32'd0);
        for (int c = 1; c <= 75; c++) begin
            step();
            // ch1 becomes 4/1 after the wrap in cycle 29; sync in cycle 57 restarts both.
            e0 = (c < 59) ? (((c - 1) % 10) < 5) : (((c - 59) % 10) < 5);
            if (c <= 30)      e1 = ((c - 1) % 10) < 5;
            else if (c < 59)  e1 = ((c - 31) % 4) == 0;
            else              e1 = ((c - 59) % 4) == 0;
            check($sformatf("wave_c%0d", c), 32'(clk_out), 32'({e1, e0}));
`ifdef CLKDIV_TICK_EN
            check($sformatf("tick0_c%0d", c), 32'(tick[0]),
                  32'((c < 59) ? (((c - 1) % 10) == 0) : (((c - 59) % 10) == 0)));
`endif
            case (c)
                23: begin
                    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd4; cfg_high = 8'd1;
                    #1 check("ready_before_cfg1", 32'(cfg_ready), 32'd1);
                end
                24: begin
                    check("err_legal", 32'(cfg_err), 32'd0);
                    cfg_valid = 1'b0;
                    #1 check("ready_pending_c24", 32'(cfg_ready), 32'd0);
                end
                25, 26, 27, 28, 29: check($sformatf("ready_pending_c%0d", c), 32'(cfg_ready), 32'd0);
                30: check("ready_after_wrap", 32'(cfg_ready), 32'd1);
                41: begin
                    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd1; cfg_high = 8'd0;
                    cfg_valid2 = 1'b1; cfg_ch2 = 2'd3; cfg_period2 = 8'd5; cfg_high2 = 8'd2;
                    #1;
                    check("ready_ill1", 32'(cfg_ready), 32'd1);
                    check("ready_badch", 32'(cfg_ready2), 32'd1);
                end
                42: begin
                    check("err_ill1", 32'(cfg_err), 32'd1);
                    check("err_badch", 32'(cfg_err2), 32'd1);
                    cfg_valid = 1'b0; cfg_valid2 = 1'b0;
                end
                43: begin
                    check("err_ill1_end", 32'(cfg_err), 32'd0);
                    check("err_badch_end", 32'(cfg_err2), 32'd0);
                    cfg_valid = 1'b1; cfg_period = 8'd5; cfg_high = 8'd5;
                end
                44: begin
                    check("err_ill2", 32'(cfg_err), 32'd1);
                    cfg_valid = 1'b0;
                    #1 check("ready_after_ill", 32'(cfg_ready), 32'd1);
                end
                45: check("err_ill2_end", 32'(cfg_err), 32'd0);
                57: sync = 1'b1;
                58: sync = 1'b0;
                default: ;
            endcase
        end

        // Disabled channel: update applies the cycle after acceptance.
        en = 2'b01;
        step();
        check("dis_low", 32'(clk_out[1]), 32'd0);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd6; cfg_high = 8'd2;
        step();
        cfg_valid = 1'b0;
        #1 check("dis_pending", 32'(cfg_ready), 32'd0);
        step();
        check("dis_applied", 32'(cfg_ready), 32'd1);
        en = 2'b11;
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("dis_wave_%0d", j), 32'(clk_out[1]), 32'(((j - 1) % 6) < 2));
        end

        // Pending update on ch0 discarded by an asynchronous reset.
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd6; cfg_high = 8'd3;
        step();
        cfg_valid = 1'b0;
        #1 check("rst_pend_set", 32'(cfg_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(cfg_ready), 32'd1);
        check("async_rst_out", 32'(clk_out), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            e0 = ((c - 1) % 10) < 5;
            check($sformatf("post_rst_c%0d", c), 32'(clk_out), 32'({e0, e0}));
        end
        check("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
